seg_rx_decoder: RTL
===================

Name: seg_rx_decoder

Overview:
- Receive end of the 7-segment interface: samples the eight segment lines driven by a BCD counter and segment decoder.
- Filters the pattern for stability and decodes it back to a BCD digit, with valid, blank and error flags.
- Emits a one-cycle strobe on each newly accepted digit.
- Used as an on-board loopback monitor and self-check for counter/display designs.

Parameters:
- STABLE_CYCLES, 16, consecutive synchronized samples a pattern must persist before acceptance; legal range 2..65535.
- SEG_ACTIVE_HIGH, 1, segment polarity: 1 = lit segment is logic 1; 0 = lit segment is logic 0.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- segA..segG  input  1 each  segment lines a..g, asynchronous to clk
- segDP  input  1  decimal point line, asynchronous to clk
- BCD  output  4  last accepted digit
- dp  output  1  decimal point of last accepted pattern, normalized so 1 = lit
- valid  output  1  last accepted pattern was a legal digit 0..9
- blank  output  1  last accepted pattern had all of a..g unlit
- err  output  1  last accepted pattern was neither a digit nor blank
- strobe  output  1  one-cycle pulse when a new digit is accepted
- seq_err  output  1  one-cycle pulse on a counting-sequence violation (optional feature)

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0. Synchronizers, candidate register and counter are set to the all-unlit normalized pattern and 0. State = ACQUIRE.
- Input path: 2-FF synchronizer on all 8 lines.
  - Inputs are normalized to lit=1 via SEG_ACTIVE_HIGH.
  - P = {g,f,e,d,c,b,a}, with a as bit 0.
- Stability filter:
  - cand register holds the previous synchronized P.
  - cnt clears to 0 whenever the synchronized P differs from cand; otherwise it increments, saturating at STABLE_CYCLES.
- Acceptance occurs on the edge at which P has been identical for STABLE_CYCLES consecutive synchronized samples. Latency from a pin change to the output update = STABLE_CYCLES+2 clk edges.
- Each stable pattern is accepted exactly once. After acceptance the state is LOCKED, with cnt saturated.
- Any change to P returns the state to ACQUIRE.
- Legal digit patterns (hex P):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66
  - 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - Any other nonzero pattern is an error.
- On acceptance of a digit:
  - BCD <= digit, valid <= 1, blank <= 0, err <= 0.
  - strobe = 1 for one cycle if the previous valid was 0 or the digit differs from the current BCD.
- On acceptance of blank (P = 00): valid <= 0, blank <= 1, err <= 0; BCD is held; no strobe.
- On acceptance of an illegal pattern: valid <= 0, blank <= 0, err <= 1; BCD is held; no strobe.
- dp is updated on every acceptance, independent of P classification. A change on DP alone also restarts the stability filter.
- Glitches shorter than STABLE_CYCLES samples produce no output change. When the original pattern returns and is re-accepted, there is no strobe because the digit is unchanged.
- Reset mid-acquisition discards the partial count. The first post-reset acceptance always strobes if it is a digit.

Optional Feature:
- Macro SEG_RX_SEQ_CHECK_EN.
- Defined: on each digit acceptance where the prior state was valid=1 and the digit differs from BCD, seq_err pulses for one cycle (coincident with strobe) if new digit != (BCD+1) mod 10. The check covers 9->0 wrap.
- Not defined: seq_err tied to 0; no extra logic.

Test Plan:
- Reset: hold rst=0 with random segment inputs -> all outputs 0. Release rst with P = 3F held (STABLE_CYCLES=4) -> valid=1, BCD=0, strobe pulse exactly 6 edges after the first sample.
- Count sequence: drive 3F, 06, 5B ... 6F, 3F, each held 10 cycles -> 11 strobes with BCD 0..9,0. seq_err never asserts with the macro defined.
- Glitch: digit 5 (6D) stable, inject 7D for 3 cycles (STABLE_CYCLES=4) -> BCD stays 5, no strobe, flags unchanged.
- Error/blank: hold 49 -> err=1, valid=0, BCD held. Then hold 00 -> blank=1, err=0. Then 4F -> valid=1, BCD=3, strobe.
- Polarity: SEG_ACTIVE_HIGH=0, pins = ~7F with DP pin 0 -> BCD=8, dp=1, valid=1.
- Sequence check (macro on): digits 3 then 5 -> seq_err pulse coincident with the strobe for 5. Digits 9 then 0 -> no seq_err.

Source files
------------

// File: rtl/seg_rx_decoder.sv
// seg_rx_decoder: 7-segment receiver with synchronizer, stability filter and BCD decode.
// Define SEG_RX_SEQ_CHECK_EN to enable the counting-sequence check on seq_err.
module seg_rx_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter bit SEG_ACTIVE_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       segA,
  input  logic       segB,
  input  logic       segC,
  input  logic       segD,
  input  logic       segE,
  input  logic       segF,
  input  logic       segG,
  input  logic       segDP,
  output logic [3:0] BCD,
  output logic       dp,
  output logic       valid,
  output logic       blank,
  output logic       err,
  output logic       strobe,
  output logic       seq_err
);
  typedef enum logic {ACQUIRE, LOCKED} state_t;
  localparam logic [7:0] UNLIT = SEG_ACTIVE_HIGH ? 8'h00 : 8'hFF;
  logic [7:0] sync1, sync2, p, cand;
  logic [15:0] cnt;
  state_t state, state_nx;
  logic same, accept, is_digit;
  logic [3:0] digit;
  // raw pins are synchronized before normalization so reset loads the unlit level
  assign p = sync2 ^ UNLIT;
  assign same = p == cand;
  always_comb begin
    accept = state == ACQUIRE && same && cnt == 16'(STABLE_CYCLES - 2);
    state_nx = !same ? ACQUIRE : (accept ? LOCKED : state);
  end
  always_comb begin
    is_digit = 1'b1;
    digit = 4'd0;
    case (p[6:0])
      7'h3F: digit = 4'd0;
      7'h06: digit = 4'd1;
      7'h5B: digit = 4'd2;
      7'h4F: digit = 4'd3;
      7'h66: digit = 4'd4;
      7'h6D: digit = 4'd5;
      7'h7D: digit = 4'd6;
      7'h07: digit = 4'd7;
      7'h7F: digit = 4'd8;
      7'h6F: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= UNLIT;
      sync2 <= UNLIT;
      cand <= 8'h00;
      cnt <= 16'd0;
      state <= ACQUIRE;
      BCD <= 4'd0;
      dp <= 1'b0;
      valid <= 1'b0;
      blank <= 1'b0;
      err <= 1'b0;
      strobe <= 1'b0;
    end else begin
      sync1 <= {segDP, segG, segF, segE, segD, segC, segB, segA};
      sync2 <= sync1;
      cand <= p;
      cnt <= !same ? 16'd0 : (cnt == 16'(STABLE_CYCLES) ? cnt : cnt + 16'd1);
      state <= state_nx;
      strobe <= accept && is_digit && (!valid || digit != BCD);
      if (accept) begin
        dp <= p[7];
        valid <= is_digit;
        blank <= p[6:0] == 7'h00;
        err <= !is_digit && p[6:0] != 7'h00;
        if (is_digit) BCD <= digit;
      end
    end
`ifdef SEG_RX_SEQ_CHECK_EN
  logic [3:0] bcd_next;
  assign bcd_next = BCD == 4'd9 ? 4'd0 : BCD + 4'd1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) seq_err <= 1'b0;
    else seq_err <= accept && is_digit && valid && digit != BCD && digit != bcd_next;
`else
  assign seq_err = 1'b0;
`endif
endmodule
